tiny_bnn: RTL and testbench

Single-layer binary neural network core: 8 binary inputs and 8 binary neurons, each with 8 XNOR weights and a 4-bit firing threshold. Weights and thresholds are loaded serially through a 96-bit parameter shift register while `setup` is high. The 8-bit input vector is loaded as two nibbles. The block sits under the Tiny Tapeout top wrapper, which maps its pins to `ui_in[7:0]` / `uo_out[7:0]`.

---
 rtl/tiny_bnn_pkg.sv | 21 ++
 rtl/tiny_bnn_if.sv | 14 +
 rtl/bnn_neuron.sv | 24 ++
 rtl/tiny_bnn.sv | 46 ++++
 tb/tb_tiny_bnn.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_bnn_pkg.sv
// Shared sizes and parameter-field helpers for the tiny binary neural network core.
package tiny_bnn_pkg;

   localparam int unsigned N_IN       = 8;
   localparam int unsigned N_NEURON   = 8;
   localparam int unsigned THR_W      = 4;
   localparam int unsigned FIELD_W    = N_IN + THR_W;
   localparam int unsigned PARAM_BITS = N_NEURON * FIELD_W;
   localparam int unsigned NIB_W      = N_IN / 2;

   // LSB of neuron j's weight field inside the parameter register
   function automatic int unsigned w_lsb(int unsigned j);
      return j * FIELD_W;
   endfunction

   // LSB of neuron j's threshold field (sits just above its weights)
   function automatic int unsigned t_lsb(int unsigned j);
      return j * FIELD_W + N_IN;
   endfunction

endpackage

// File: rtl/tiny_bnn_if.sv
// Pin bundle between the Tiny Tapeout wrapper and the BNN core.
interface tiny_bnn_if;
   import tiny_bnn_pkg::*;

   logic                setup;
   logic                param_in;
   logic                x_bank_hi;
   logic [NIB_W-1:0]    x_nib;
   logic [N_NEURON-1:0] out;

   modport master (output setup, output param_in, output x_bank_hi, output x_nib, input out);
   modport slave  (input setup, input param_in, input x_bank_hi, input x_nib, output out);

endinterface

// File: rtl/bnn_neuron.sv
// One binary neuron: XNOR the inputs with the weights, count matches, fire at threshold.
module bnn_neuron
   import tiny_bnn_pkg::*;
(
   input  logic [N_IN-1:0]  x,
   input  logic [N_IN-1:0]  w,
   input  logic [THR_W-1:0] t,
   output logic             fire
);

   logic [THR_W-1:0] match_cnt;

   // Popcount of XNOR matches; 0..8 fits in THR_W bits
   always_comb begin
      match_cnt = '0;
      for (int i = 0; i < N_IN; i++) begin
         match_cnt = match_cnt + THR_W'(x[i] ~^ w[i]);
      end
   end

   // Unsigned compare: t=0 always fires, t>=9 never fires
   assign fire = (match_cnt >= t);

endmodule

// File: rtl/tiny_bnn.sv
// Single-layer BNN core: serial parameter shift register, nibble-loaded input
// register and registered neuron outputs.
module tiny_bnn
   import tiny_bnn_pkg::*;
(
   input logic       clk,
   input logic       rst,
   tiny_bnn_if.slave bus
);

   logic [PARAM_BITS-1:0] param_q;
   logic [N_IN-1:0]       x_q;
   logic [N_NEURON-1:0]   out_q;
   logic [N_NEURON-1:0]   fire;

   for (genvar j = 0; j < N_NEURON; j++) begin : g_neuron
      bnn_neuron u_neuron (
         .x    (x_q),
         .w    (param_q[w_lsb(j) +: N_IN]),
         .t    (param_q[t_lsb(j) +: THR_W]),
         .fire (fire[j])
      );
   end

   // Setup shifts parameters in (newest bit at 0); run mode loads a nibble and
   // registers the neuron outputs computed from the previous x_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         param_q <= '0;
         x_q     <= '0;
         out_q   <= '0;
      end else if (bus.setup) begin
         param_q <= {param_q[PARAM_BITS-2:0], bus.param_in};
      end else begin
         if (bus.x_bank_hi) begin
            x_q[N_IN-1:NIB_W] <= bus.x_nib;
         end else begin
            x_q[NIB_W-1:0] <= bus.x_nib;
         end
         out_q <= fire;
      end
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_tiny_bnn.sv
// Scoreboard bench for tiny_bnn: driver pushes model predictions, monitor pops and compares.
module tb_tiny_bnn;

   typedef struct {
      logic [7:0] exp;
      bit         has_c;
      logic [7:0] cval;
      int         tag;
   } item_t;

   logic clk;
   logic rst;
   bit   fin;
   tiny_bnn_if bus ();

   tiny_bnn dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: shifted-in bit history, input byte, output byte
   bit          sq[$];
   int unsigned mx;
   logic [7:0]  mout;
   item_t       expq[$];
   int          total;
   int          bad;

   // Directed parameter sets (weights/thresholds per neuron)
   logic [7:0] tw[8];
   logic [3:0] tt[8];

   // Bit k of the parameter register = k-th most recent bit shifted in
   function automatic int reg_bit(int k);
      int n = sq.size();
      if (k < n) return int'(sq[n-1-k]);
      return 0;
   endfunction

   function automatic logic [7:0] model_out();
      logic [7:0] r = '0;
      for (int j = 0; j < 8; j++) begin
         int wj = 0;
         int tj = 0;
         int m  = 0;
         for (int i = 0; i < 8; i++) wj = wj | (reg_bit(12*j + i) << i);
         for (int i = 0; i < 4; i++) tj = tj | (reg_bit(12*j + 8 + i) << i);
         for (int i = 0; i < 8; i++) if (((mx >> i) & 1) == ((wj >> i) & 1)) m++;
         if (m >= tj) r[j] = 1'b1;
      end
      return r;
   endfunction

   // Drive one clock's inputs, predict the response, wait past the edge
   task automatic cycle(input bit s, input bit pin, input bit hi, input logic [3:0] nib,
                        input int cv, input int tag);
      item_t it;
      bus.setup     = s;
      bus.param_in  = pin;
      bus.x_bank_hi = hi;
      bus.x_nib     = nib;
      if (s) begin
         sq.push_back(pin);
         if (sq.size() > 96) void'(sq.pop_front());
      end else begin
         mout = model_out();
         if (hi) mx = (mx & 32'h0F) | (int'(nib) << 4);
         else    mx = (mx & 32'hF0) | int'(nib);
      end
      it.exp   = mout;
      it.has_c = (cv >= 0);
      it.cval  = cv[7:0];
      it.tag   = tag;
      expq.push_back(it);
      @(posedge clk);
      #3;
   endtask

   // Full x load: low nibble, high nibble, one more edge to evaluate
   task automatic load_x(input logic [7:0] v, input int cv, input int tag);
      cycle(1'b0, 1'b0, 1'b0, v[3:0], -1, tag);
      cycle(1'b0, 1'b0, 1'b1, v[7:4], -1, tag);
      cycle(1'b0, 1'b0, 1'b1, v[7:4], cv, tag);
   endtask

   // Stream t7,w7,...,t0,w0 MSB first; optionally wiggle the x pins meanwhile
   task automatic prog(input bit wiggle, input int tag);
      for (int j = 7; j >= 0; j--) begin
         for (int b = 3; b >= 0; b--)
            cycle(1'b1, tt[j][b], wiggle & $urandom_range(0, 1), 4'($urandom), -1, tag);
         for (int b = 7; b >= 0; b--)
            cycle(1'b1, tw[j][b], wiggle & $urandom_range(0, 1), 4'($urandom), -1, tag);
      end
   endtask

   task automatic model_reset();
      sq.delete();
      mx   = 0;
      mout = '0;
   endtask

   // Monitor: sole owner of the counters; checks reset, scoreboard items, final drain
   initial begin
      item_t it;
      total = 0;
      bad   = 0;
      forever begin
         @(posedge clk or posedge rst or posedge fin);
         if (fin) begin
            total++;
            if (expq.size() != 0) begin
               bad++;
               $display("FAIL drain: %0d items left, want 0", expq.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end else if (rst) begin
            #1;
            total++;
            if (bus.out !== 8'h00) begin
               bad++;
               $display("FAIL reset_out: got %02h want 00", bus.out);
            end
         end else begin
            #1;
            if (expq.size() > 0) begin
               it = expq.pop_front();
               total++;
               if (bus.out !== it.exp) begin
                  bad++;
                  $display("FAIL sb tag=%0d: got %02h want %02h", it.tag, bus.out, it.exp);
               end
               if (it.has_c) begin
                  total++;
                  if (bus.out !== it.cval) begin
                     bad++;
                     $display("FAIL const tag=%0d: got %02h want %02h", it.tag, bus.out, it.cval);
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      fin           = 1'b0;
      rst           = 1'b1;
      bus.setup     = 1'b0;
      bus.param_in  = 1'b0;
      bus.x_bank_hi = 1'b0;
      bus.x_nib     = 4'h0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // All-zero params: every neuron fires
      cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'hFF, 1);

      // AND detector
      for (int j = 0; j < 8; j++) begin tw[j] = 8'hFF; tt[j] = 4'd8; end
      prog(1'b0, 2);
      load_x(8'hFF, 8'hFF, 3);
      cycle(1'b0, 1'b0, 1'b0, 4'hE, 8'hFF, 4);
      cycle(1'b0, 1'b0, 1'b0, 4'hE, 8'h00, 5);

      // Thermometer
      for (int j = 0; j < 8; j++) begin tw[j] = 8'hFF; tt[j] = 4'(j + 1); end
      prog(1'b0, 6);
      load_x(8'h0F, 8'h0F, 7);
      load_x(8'h00, 8'h00, 8);
      load_x(8'hFF, 8'hFF, 9);

      // XNOR match on neuron 0 only
      for (int j = 0; j < 8; j++) begin tw[j] = 8'h00; tt[j] = 4'd15; end
      tw[0] = 8'hA5;
      tt[0] = 4'd8;
      prog(1'b0, 10);
      load_x(8'hA5, 8'h01, 11);
      load_x(8'h5A, 8'h00, 12);

      // Setup hold with wiggled x pins, then 12 extra bits slide fields up one neuron
      load_x(8'h0F, -1, 13);
      for (int j = 0; j < 8; j++) begin tw[j] = 8'hFF; tt[j] = 4'(j + 1); end
      prog(1'b1, 14);
      cycle(1'b0, 1'b0, 1'b1, 4'h0, 8'h0F, 15);
      for (int b = 0; b < 12; b++) cycle(1'b1, 1'b0, b[0], 4'($urandom), 8'h0F, 16);
      // neuron 0 now w=00,t=0 (fires); neuron j takes old t=j -> x=0F fires j<=4
      cycle(1'b0, 1'b0, 1'b1, 4'h0, 8'h1F, 17);

      // Async reset in the middle of a shift
      load_x(8'hFF, 8'hFF, 18);
      for (int b = 0; b < 40; b++) cycle(1'b1, 1'($urandom), 1'b0, 4'h0, -1, 19);
      #1;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'hFF, 20);

      // Random params and random mixed traffic
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 8; j++) begin tw[j] = 8'($urandom); tt[j] = 4'($urandom_range(0, 9)); end
         prog(1'b1, 21);
         for (int k = 0; k < 150; k++)
            cycle($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 4'($urandom), -1, 22);
      end

      @(negedge clk);
      fin = 1'b1;
      #20;
   end

endmodule
